// File: rtl/uart_pkg.sv
// Shared types and limits for the UART transmit path: state encoding, legal parameter bounds
// and the clock-to-bit-period divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;
  localparam int DIV_MIN       = 4;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side byte handshake of the UART transmitter; the host is master, the transmitter slave.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_en_sig;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done_sig;

  modport master (output tx_en_sig, output tx_data,
                  input  tx_ready, input tx_busy, input tx_done_sig);
  modport slave  (input  tx_en_sig, input tx_data,
                  output tx_ready, output tx_busy, output tx_done_sig);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts while run is high, cleared while low, one-cycle tick at DIV-1.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || cnt_q == LAST) cnt_d = '0;
    else                       cnt_d = cnt_q + 1'b1;
  end

  assign tick = run && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-entry holding register for gap-free back-to-back frames.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_frame_if.slave   host,
  output logic             tx_pin_out
);
  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int IW  = $clog2(DATA_BITS + 1);

  localparam logic [2:0]    S_IDLE    = IDLE;
  localparam logic [2:0]    S_START   = START;
  localparam logic [2:0]    S_DATA    = DATA;
  localparam logic [2:0]    S_STOP    = STOP;
  localparam logic [IW-1:0] IDX_DLAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_SLAST = IW'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0]    S_PARITY  = PARITY;
`endif

  if (DIV < DIV_MIN) begin : g_chk_div
    $error("uart_tx_frame: CLK_FREQ_HZ/BAUD must be at least 4");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_chk_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_chk_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_par
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 pin_q, pin_d;
  logic                 bit_tick, run, load, ready, accept;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign run = (state_q != S_IDLE);

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tick (bit_tick)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      S_IDLE:  if (hold_full_q) load = 1'b1;
      S_START: if (bit_tick) begin
        state_d = S_DATA;
        idx_d   = '0;
      end
      S_DATA:  if (bit_tick) begin
        shift_d = shift_q >> 1;
        if (idx_q == IDX_DLAST) begin
          idx_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_tick) begin
        state_d = S_STOP;
        idx_d   = '0;
      end
`endif
      S_STOP:  if (bit_tick) begin
        if (idx_q == IDX_SLAST) begin
          done_d = 1'b1;
          idx_d  = '0;
          // A queued byte chains straight into the next start bit
          if (hold_full_q) load = 1'b1;
          else             state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d     = S_START;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d       = (^hold_q) ^ PARITY_ODD[0];
`endif
    end

    // Unloading frees the slot in the same cycle, so a write can land alongside it
    ready  = !hold_full_q || load;
    accept = host.tx_en_sig && ready;
    if (accept) begin
      hold_d      = host.tx_data;
      hold_full_d = 1'b1;
    end

    case (state_d)
      S_START:   pin_d = 1'b0;
      S_DATA:    pin_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY:  pin_d = par_d;
`endif
      default:   pin_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      pin_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      pin_q       <= pin_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign host.tx_ready    = ready;
  assign host.tx_busy     = run;
  assign host.tx_done_sig = done_q;
  assign tx_pin_out       = pin_q;
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that succeeds the fixed 8N1 transmit path. It supports configurable data width, stop-bit count and an optional parity bit. A one-entry holding register accepts the next byte while the current frame is shifting, so back-to-back frames go out with no idle gap. It sits between the host-side byte source and the serial pin, and keeps the `tx_en_sig`/`tx_done_sig` semantics familiar from the existing transmitter.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 9600, line rate. Bit period `DIV = CLK_FREQ_HZ / BAUD` (integer division, `DIV >= 4`; elaboration error otherwise).
- `DATA_BITS`, 8, payload width, legal 5..9 (elaboration error otherwise).
- `STOP_BITS`, 1, legal 1 or 2.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity; meaningful only with the parity macro.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_en_sig` in 1: write request. Qualified by `tx_ready`.
- `tx_data` in `DATA_BITS`: payload, sampled on the accept cycle.
- `tx_ready` out 1: holding register empty; a write is accepted when `tx_en_sig && tx_ready`.
- `tx_busy` out 1: a frame is on the line (FSM not IDLE).
- `tx_done_sig` out 1: one-cycle pulse at the end of each frame.
- `tx_pin_out` out 1: serial line, idle high.

## Operation
- Reset values: `tx_pin_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done_sig`=0. Holding register and shifter are cleared, and the FSM is in IDLE.
- **Accept.** On an accepted write, `tx_data` is latched into the holding register and `tx_ready` drops the next cycle. `tx_en_sig` while `tx_ready`=0 is ignored; no overwrite and no error.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the holding register is full. The holding register moves to the shifter and `tx_ready` rises the same cycle.
  - START -> DATA after 1 bit period.
  - DATA -> PARITY (macro on) or STOP (macro off) after `DATA_BITS` periods.
  - PARITY -> STOP after 1 period.
  - STOP -> START directly if the holding register is full at the final stop cycle; otherwise STOP -> IDLE.
- **Line levels:**
  - START drives 0.
  - DATA sends LSB first.
  - PARITY sends the XOR of the data bits, inverted when `PARITY_ODD`=1.
  - STOP drives 1 for `STOP_BITS` periods.
- **Baud counter:** width `$clog2(DIV)`. It is reset to 0 on entry to START and wraps at `DIV-1`, which produces a bit-end tick. The counter is held at 0 in IDLE.
- **Bit index counter:** width `$clog2(DATA_BITS+1)`. It counts data bits in DATA and stop bits in STOP.
- `tx_pin_out` is registered, giving a glitch-free output.
- **Simultaneous events:** a write may be accepted in the same cycle the holding register unloads into the shifter. `tx_ready` rises, so the write sees `tx_ready`=1 and is accepted that cycle.

## Timing
- **Write to line:** write accepted at cycle N while IDLE with holding empty. The holding register is full at N+1, the FSM enters START at N+2, and `tx_pin_out` falls at N+2.
- **Frame length:** `(1 + DATA_BITS + P + STOP_BITS) * DIV` cycles, where P = 1 with the macro and P = 0 without it.
- **Done pulse:** `tx_done_sig` is high for exactly the cycle after the last stop-bit cycle. It coincides with the first cycle of the next START when frames are back-to-back.
- **Back-to-back:** when the next frame is queued, the last stop bit is followed immediately by a start bit, with zero idle cycles.
- **Reset mid-frame:** outputs return to their reset values asynchronously. The frame in flight and the held byte are discarded, and no `tx_done_sig` is generated.

## Configuration
- Macro `UART_TX_PARITY_EN`:
  - **Defined:** the PARITY state is compiled in and every frame carries one parity bit per `PARITY_ODD`.
  - **Undefined:** the PARITY state and its logic are absent. DATA goes directly to STOP and `PARITY_ODD` is ignored.

## Structure
- Package `uart_pkg`:
  - `tx_state_e` enum (IDLE, START, DATA, PARITY, STOP).
  - function `calc_div(clk_hz, baud)`.
  - localparams for the legal `DATA_BITS`/`STOP_BITS` bounds.
- Sub-module `uart_baud_tick`:
  - Parameter `DIV`.
  - Ports: `clk`, `rst_n`, `run`, `tick`.
  - Behaviour: a free counter cleared while `run`=0, with a single-cycle `tick` at `DIV-1`.
- Top-level contents: FSM, holding register, shifter and output register.

## Test plan
- Single frame with `CLK_FREQ_HZ`=1000, `BAUD`=100 (`DIV`=10), macro off, write 0x55: line low at N+2, bits 1,0,1,0,1,0,1,0 at 10 cycles each, then high. `tx_done_sig` pulses once, 100 cycles after the start edge.
- Back-to-back: write 0xA3, then 0x0F while `tx_busy`. Exactly 2 frames, no idle cycle between stop and start, 2 done pulses. A third write while `tx_ready`=0 is dropped.
- Parity with macro on, `DATA_BITS`=7:
  - `PARITY_ODD`=0, data 0x07: parity bit = 1.
  - `PARITY_ODD`=1, data 0x07: parity bit = 0.
  - Frame length is 10 bit periods in both cases.
- `STOP_BITS`=2, `DATA_BITS`=5, data 0x1F: stop high for 20 cycles (`DIV`=10). Total frame 80 cycles.
- Reset asserted midway through DATA of frame 1 with a byte held: `tx_pin_out`=1 immediately, `tx_ready`=1, `tx_busy`=0, no `tx_done_sig`. After reset release, the line stays idle until a new write.
